wb_master_bridge: RTL and testbench
===================================

WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

Interface
REQ-001 Parameter MAX_RETRY, default 3: number of re-issues allowed after rty_i before the transfer fails.
REQ-002 Parameter TIMEOUT, default 255: number of cycles ACTIVE waits for ack_i/err_i/rty_i before the transfer fails.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_valid  in  1  command present.
REQ-006 req_ready  out  1  bridge accepts a command this cycle.
REQ-007 req_we  in  1  1 = write, 0 = read.
REQ-008 req_adr  in  32  byte address.
REQ-009 req_sel  in  4  byte lanes.
REQ-010 req_dat  in  32  write data.
REQ-011 rsp_valid  out  1  one-cycle response pulse.
REQ-012 rsp_dat  out  32  read data; 0 for writes and failures.
REQ-013 rsp_err  out  1  transfer failed (err_i, retries exhausted, or timeout).
REQ-014 adr_o 32, sel_o 4, we_o 1, dat_o 32, stb_o 1, cyc_o 1, cti_o 3, bte_o 2  out  Wishbone initiator signals.
REQ-015 dat_i 32, ack_i 1, err_i 1, rty_i 1  in  Wishbone responder signals.

Function
REQ-016 States: IDLE, ACTIVE, BACKOFF, RESP; encoding is free.
REQ-017 req_ready SHALL be 1 only in IDLE; a command is accepted on the cycle where req_valid && req_ready.
REQ-018 On acceptance: latch we/adr/sel/dat into Wishbone output registers, clear retry and timeout counters, go to ACTIVE.
REQ-019 In ACTIVE: cyc_o = stb_o = 1, cti_o = 3'b000 (classic), bte_o = 2'b00; outputs stay stable until termination.
REQ-020 Termination priority when several are asserted in the same cycle: err_i > ack_i > rty_i.
REQ-021 ack_i in ACTIVE: capture dat_i into rsp_dat if read (0 if write), rsp_err = 0, go to RESP.
REQ-022 err_i in ACTIVE: rsp_dat = 0, rsp_err = 1, go to RESP.
REQ-023 rty_i in ACTIVE with retry count < MAX_RETRY: increment the retry count, clear the timeout counter, go to BACKOFF.
REQ-024 rty_i in ACTIVE with retry count == MAX_RETRY: rsp_err = 1, rsp_dat = 0, go to RESP.
REQ-025 BACKOFF lasts exactly one cycle with cyc_o = stb_o = 0, then returns to ACTIVE with the same latched command.
REQ-026 Timeout counter increments each ACTIVE cycle without a termination signal.
REQ-027 When the timeout counter reaches TIMEOUT: rsp_err = 1, rsp_dat = 0, go to RESP; cyc_o/stb_o drop on the next cycle.
REQ-028 RESP: rsp_valid = 1 for exactly one cycle, cyc_o = stb_o = 0, then IDLE; no back-to-back commands, so there is at least one idle bus cycle between transfers.
REQ-029 ack_i/err_i/rty_i outside ACTIVE are ignored.
REQ-030 Latency: ack_i on the first ACTIVE cycle gives rsp_valid 2 cycles after acceptance.

Reset
REQ-031 While rst = 1, independent of clk: state = IDLE; cyc_o, stb_o, we_o, rsp_valid, rsp_err = 0; adr_o, dat_o, rsp_dat = 0; sel_o, cti_o, bte_o = 0; counters = 0.
REQ-032 Reset mid-transfer aborts the transfer immediately with no response pulse; after reset release, req_ready = 1 on the first clock edge.

Verification
REQ-033 Write adr 0x10, dat 0xDEADBEEF, sel 4'hF; responder acks on the 2nd ACTIVE cycle -> one rsp_valid, rsp_err = 0, rsp_dat = 0, and a responder read of 0x10 returns 0xDEADBEEF.
REQ-034 Read adr 0x10 with ack_i on the first cycle, dat_i = 0x12345678 -> rsp_valid 2 cycles after acceptance with rsp_dat = 0x12345678.
REQ-035 Responder asserts rty_i twice, then ack_i -> exactly 2 one-cycle cyc_o drops, rsp_err = 0.
REQ-036 Responder asserts rty_i 4 times with MAX_RETRY = 3 -> rsp_err = 1 after the 4th rty_i, rsp_dat = 0.
REQ-037 Responder stays silent with TIMEOUT = 8 -> rsp_err = 1, cyc_o low by 10 cycles after acceptance; err_i and ack_i in the same cycle -> rsp_err = 1.
REQ-038 rst pulse while in ACTIVE -> cyc_o = 0 immediately, no rsp_valid; a new command is accepted on the first edge after release.

Source files
------------

// File: rtl/wb_master_bridge.sv
// Single-command Wishbone classic initiator: accepts one request, runs it on the bus
// with retry/backoff and timeout handling, and returns a one-cycle response pulse.
module wb_master_bridge #(
   parameter int MAX_RETRY = 3,
   parameter int TIMEOUT   = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_adr,
   input  logic [3:0]  req_sel,
   input  logic [31:0] req_dat,
   output logic        rsp_valid,
   output logic [31:0] rsp_dat,
   output logic        rsp_err,
   output logic [31:0] adr_o,
   output logic [3:0]  sel_o,
   output logic        we_o,
   output logic [31:0] dat_o,
   output logic        stb_o,
   output logic        cyc_o,
   output logic [2:0]  cti_o,
   output logic [1:0]  bte_o,
   input  logic [31:0] dat_i,
   input  logic        ack_i,
   input  logic        err_i,
   input  logic        rty_i
);

   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
   localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BACKOFF, S_RESP} state_t;

   state_t          state_q, state_d;
   logic [31:0]     adr_q, adr_d;
   logic [3:0]      sel_q, sel_d;
   logic            we_q, we_d;
   logic [31:0]     dat_q, dat_d;
   logic [RW-1:0]   retry_q, retry_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [31:0]     rsp_dat_q, rsp_dat_d;
   logic            rsp_err_q, rsp_err_d;
   logic [TW-1:0]   tmo_inc;

   assign tmo_inc = tmo_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      adr_d     = adr_q;
      sel_d     = sel_q;
      we_d      = we_q;
      dat_d     = dat_q;
      retry_d   = retry_q;
      tmo_d     = tmo_q;
      rsp_dat_d = rsp_dat_q;
      rsp_err_d = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               adr_d     = req_adr;
               sel_d     = req_sel;
               we_d      = req_we;
               dat_d     = req_dat;
               retry_d   = '0;
               tmo_d     = '0;
               rsp_dat_d = '0;
               rsp_err_d = 1'b0;
               state_d   = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            // err beats ack beats rty when a responder raises several at once
            if (err_i) begin
               rsp_dat_d = '0;
               rsp_err_d = 1'b1;
               state_d   = S_RESP;
            end else if (ack_i) begin
               rsp_dat_d = we_q ? 32'h0 : dat_i;
               rsp_err_d = 1'b0;
               state_d   = S_RESP;
            end else if (rty_i) begin
               if (retry_q == RETRY_MAX) begin
                  rsp_dat_d = '0;
                  rsp_err_d = 1'b1;
                  state_d   = S_RESP;
               end else begin
                  retry_d = retry_q + 1'b1;
                  tmo_d   = '0;
                  state_d = S_BACKOFF;
               end
            end else begin
               tmo_d = tmo_inc;
               if (tmo_inc == TMO_MAX) begin
                  rsp_dat_d = '0;
                  rsp_err_d = 1'b1;
                  state_d   = S_RESP;
               end
            end
         end
         S_BACKOFF: state_d = S_ACTIVE;
         S_RESP:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         adr_q     <= '0;
         sel_q     <= '0;
         we_q      <= 1'b0;
         dat_q     <= '0;
         retry_q   <= '0;
         tmo_q     <= '0;
         rsp_dat_q <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         adr_q     <= adr_d;
         sel_q     <= sel_d;
         we_q      <= we_d;
         dat_q     <= dat_d;
         retry_q   <= retry_d;
         tmo_q     <= tmo_d;
         rsp_dat_q <= rsp_dat_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   // Bus strobes follow the state register so a reset drops them without waiting for a clock
   assign req_ready = (state_q == S_IDLE);
   assign cyc_o     = (state_q == S_ACTIVE);
   assign stb_o     = (state_q == S_ACTIVE);
   assign rsp_valid = (state_q == S_RESP);
   assign cti_o     = 3'b000;
   assign bte_o     = 2'b00;
   assign adr_o     = adr_q;
   assign sel_o     = sel_q;
   assign we_o      = we_q;
   assign dat_o     = dat_q;
   assign rsp_dat   = rsp_dat_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Randomized bench for wb_master_bridge: a scripted Wishbone responder plus a
// transaction-level model predicting response cycle, error, data and backoff count.
module tb_wb_master_bridge;

   localparam int MAX_RETRY = 3;
   localparam int TIMEOUT   = 8;
   localparam int T_ACK = 0, T_ERR = 1, T_RTY = 2, T_NONE = 3, T_EA = 4, T_RA = 5, T_RE = 6;

   logic        clk, rst;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_adr, req_dat;
   logic [3:0]  req_sel;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_dat;
   logic [31:0] adr_o, dat_o, dat_i;
   logic [3:0]  sel_o;
   logic        we_o, stb_o, cyc_o, ack_i, err_i, rty_i;
   logic [2:0]  cti_o;
   logic [1:0]  bte_o;

   logic [31:0] bus_mem   [logic [31:0]];
   logic [31:0] model_mem [logic [31:0]];
   int pw [8];
   int pt [8];
   int np;
   int checks   = 0;
   int failures = 0;

   wb_master_bridge #(.MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_adr(req_adr), .req_sel(req_sel), .req_dat(req_dat),
      .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
      .adr_o(adr_o), .sel_o(sel_o), .we_o(we_o), .dat_o(dat_o),
      .stb_o(stb_o), .cyc_o(cyc_o), .cti_o(cti_o), .bte_o(bte_o),
      .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] defv(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic int rand_w();
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 6) return r % 4;
      if (r < 8) return TIMEOUT - 1;
      if (r == 8) return 1;
      return TIMEOUT;
   endfunction

   task automatic gen_plan();
      int nr, k;
      nr = int'($urandom_range(0, 4));
      np = 0;
      for (int i = 0; i < nr; i++) begin
         pw[np] = rand_w();
         pt[np] = T_RTY;
         np++;
      end
      k = int'($urandom_range(0, 6));
      pw[np] = rand_w();
      case (k)
         0, 1: pt[np] = T_ACK;
         2:    pt[np] = T_ERR;
         3:    pt[np] = T_EA;
         4:    pt[np] = T_RA;
         5:    pt[np] = T_RE;
         default: begin pt[np] = T_NONE; pw[np] = 1000; end
      endcase
      np++;
   endtask

   task automatic set_plan1(input int w, input int t);
      np = 1; pw[0] = w; pt[0] = t;
   endtask

   // Called just after a falling edge; returns just after a falling edge with the bridge idle.
   task automatic do_txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input string tag);
      int pos, retries, exp_cyc, exp_err, got_cyc, drops, j, a;
      bit done, is_ack;
      logic [31:0] mv, exp_dat, bv;
      pos = 1; retries = 0; exp_cyc = 0; exp_err = 0; done = 0;
      for (int i = 0; i < np && !done; i++) begin
         if (pw[i] >= TIMEOUT) begin
            exp_cyc = pos + TIMEOUT; exp_err = 1; done = 1;
         end else begin
            case (pt[i])
               T_ACK, T_RA: begin exp_cyc = pos + pw[i] + 1; done = 1; end
               T_ERR, T_EA, T_RE: begin exp_cyc = pos + pw[i] + 1; exp_err = 1; done = 1; end
               T_RTY: begin
                  if (retries < MAX_RETRY) begin
                     retries++;
                     pos = pos + pw[i] + 2;
                  end else begin
                     exp_cyc = pos + pw[i] + 1; exp_err = 1; done = 1;
                  end
               end
               default: ;
            endcase
         end
      end
      mv = model_mem.exists(adr) ? model_mem[adr] : defv(adr);
      exp_dat = (exp_err != 0 || we) ? 32'h0 : mv;
      if (exp_err == 0 && we) model_mem[adr] = merge(mv, dat, sel);

      check({tag, ".ready"}, 96'(req_ready), 96'(1));
      req_valid = 1'b1; req_we = we; req_adr = adr; req_sel = sel; req_dat = dat;
      @(negedge clk);
      req_valid = 1'b0; req_we = $urandom; req_adr = $urandom; req_dat = $urandom;
      req_sel = 4'($urandom);
      got_cyc = 0; drops = 0; j = 0; a = 0;
      for (int k = 1; k <= 200; k++) begin
         if (rsp_valid) begin
            got_cyc = k;
            break;
         end
         check({tag, ".busy"}, 96'(req_ready), 96'(0));
         if (cyc_o)
            check({tag, ".bus"}, 96'({we_o, sel_o, adr_o, dat_o, cti_o, bte_o, stb_o}),
                  96'({we, sel, adr, dat, 3'b000, 2'b00, 1'b1}));
         else
            drops++;
         ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; dat_i = $urandom;
         if (cyc_o && stb_o) begin
            if (j < np && a == pw[j]) begin
               is_ack = 1'b0;
               case (pt[j])
                  T_ACK: begin ack_i = 1'b1; is_ack = 1'b1; end
                  T_ERR: err_i = 1'b1;
                  T_RTY: rty_i = 1'b1;
                  T_EA:  begin err_i = 1'b1; ack_i = 1'b1; end
                  T_RA:  begin rty_i = 1'b1; ack_i = 1'b1; is_ack = 1'b1; end
                  T_RE:  begin rty_i = 1'b1; err_i = 1'b1; end
                  default: ;
               endcase
               if (ack_i) begin
                  bv = bus_mem.exists(adr_o) ? bus_mem[adr_o] : defv(adr_o);
                  if (!we_o) dat_i = bv;
                  else if (is_ack) bus_mem[adr_o] = merge(bv, dat_o, sel_o);
               end
               if (pt[j] == T_RTY) begin j++; a = 0; end
               else a++;
            end else begin
               a++;
            end
         end else if ($urandom_range(0, 3) == 0) begin
            {ack_i, err_i, rty_i} = 3'($urandom);
         end
         @(negedge clk);
      end
      check({tag, ".rsp_cycle"}, 96'(got_cyc), 96'(exp_cyc));
      check({tag, ".rsp_err"}, 96'(rsp_err), 96'(exp_err));
      check({tag, ".rsp_dat"}, 96'(rsp_dat), 96'(exp_dat));
      check({tag, ".drops"}, 96'(drops), 96'(retries));
      {ack_i, err_i, rty_i} = 3'($urandom);
      @(negedge clk);
      check({tag, ".pulse_end"}, 96'({rsp_valid, req_ready}), 96'({1'b0, 1'b1}));
      ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_sel = '0; req_dat = '0;
      dat_i = '0; ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("reset.ctl", 96'({cyc_o, stb_o, we_o, rsp_valid, rsp_err, req_ready}), 96'(6'b000001));
      check("reset.data", 96'({adr_o, dat_o, rsp_dat}), 96'(0));
      check("reset.sel", 96'({sel_o, cti_o, bte_o}), 96'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      set_plan1(1, T_ACK);
      do_txn(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, "wr10");
      check("wr10.bus_mem", 96'(bus_mem[32'h10]), 96'(32'hDEADBEEF));
      set_plan1(0, T_ACK);
      do_txn(1'b0, 32'h10, 4'hF, 32'h0, "rd10_back");

      bus_mem[32'h10] = 32'h12345678;
      model_mem[32'h10] = 32'h12345678;
      set_plan1(0, T_ACK);
      do_txn(1'b0, 32'h10, 4'hF, 32'h0, "rd10_first");

      np = 3; pw[0] = 0; pt[0] = T_RTY; pw[1] = 0; pt[1] = T_RTY; pw[2] = 0; pt[2] = T_ACK;
      do_txn(1'b0, 32'h20, 4'hF, 32'h0, "rty2");

      np = 5;
      for (int i = 0; i < 4; i++) begin pw[i] = i % 2; pt[i] = T_RTY; end
      pw[4] = 0; pt[4] = T_ACK;
      do_txn(1'b0, 32'h24, 4'hF, 32'h0, "rty4");

      set_plan1(1000, T_NONE);
      do_txn(1'b0, 32'h28, 4'hF, 32'h0, "timeout");
      set_plan1(TIMEOUT - 1, T_ACK);
      do_txn(1'b0, 32'h28, 4'hF, 32'h0, "tmo_edge");
      set_plan1(0, T_EA);
      do_txn(1'b1, 32'h2C, 4'h3, 32'hCAFEF00D, "err_ack");

      req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h30; req_sel = 4'hF; req_dat = 32'h55AA55AA;
      @(negedge clk);
      req_valid = 1'b0;
      check("rstmid.active", 96'({cyc_o, stb_o}), 96'(2'b11));
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rstmid.abort", 96'({cyc_o, stb_o, rsp_valid, req_ready}), 96'(4'b0001));
      @(negedge clk);
      check("rstmid.no_rsp", 96'({rsp_valid, adr_o}), 96'(0));
      rst = 1'b0;
      set_plan1(0, T_ACK);
      do_txn(1'b0, 32'h30, 4'hF, 32'h0, "post_rst");

      for (int n = 0; n < 60; n++) begin
         gen_plan();
         do_txn(1'($urandom), {26'h0, 4'($urandom), 2'b00}, 4'($urandom), $urandom, "rand");
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
